// File: rtl/sweep_pkg.sv
// sweep_pkg: shared FSM state type and vector-count helper for the exhaustive sweep checker.
package sweep_pkg;
   typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_SAMPLE, ST_DONE} state_t;
   function automatic int unsigned vec_count(input int unsigned n);
      return 32'd1 << n;
   endfunction
endpackage

// File: rtl/settle_timer.sv
// settle_timer: loadable down-counter that stops at zero and flags it.
module settle_timer #(
   parameter int W = 5
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         zero
);
   logic [W-1:0] cnt;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt <= '0;
      else if (load) cnt <= load_val;
      else if (cnt != '0) cnt <= cnt - 1'b1;
   end
   assign zero = cnt == '0;
endmodule

// File: rtl/exhaustive_sweep_checker.sv
// exhaustive_sweep_checker: walks every N_IN-bit vector, settles, compares DUT against golden, logs errors.
module exhaustive_sweep_checker
   import sweep_pkg::*;
#(
   parameter int N_IN   = 5,
   parameter int N_OUT  = 1,
   parameter int SETTLE = 20
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_i,
   input  logic [N_OUT-1:0] dut_i,
   input  logic [N_OUT-1:0] gold_i,
   output logic [N_IN-1:0]  stim_o,
   output logic             busy_o,
   output logic             sample_o,
   output logic             mismatch_o,
   output logic             done_o,
   output logic             pass_o,
   output logic [N_IN:0]    err_cnt_o,
   output logic [N_IN-1:0]  fail_vec_o,
   output logic             fail_valid_o
);
   localparam int TW = $clog2(SETTLE) + 1;
   localparam logic [N_IN-1:0] LAST = N_IN'(vec_count(N_IN) - 1);
   state_t state;
   logic   zero, load, last, idle_start;
   assign last       = stim_o == LAST;
   assign idle_start = (state == ST_IDLE || state == ST_DONE) && start_i;
   assign load       = idle_start || (state == ST_SAMPLE && !last);
   settle_timer #(.W(TW)) u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (load),
      .load_val (TW'(SETTLE - 1)),
      .zero     (zero)
   );
   assign sample_o   = state == ST_SAMPLE;
   // case-inequality so X/Z on either side counts as a failure in 4-state simulation
   assign mismatch_o = sample_o && (dut_i !== gold_i);
   assign busy_o     = state == ST_SETTLE || sample_o;
   assign done_o     = state == ST_DONE;
   assign pass_o     = done_o && err_cnt_o == '0;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= ST_IDLE;
         stim_o       <= '0;
         err_cnt_o    <= '0;
         fail_vec_o   <= '0;
         fail_valid_o <= 1'b0;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: if (start_i) begin
               stim_o       <= '0;
               err_cnt_o    <= '0;
               fail_vec_o   <= '0;
               fail_valid_o <= 1'b0;
               state        <= ST_SETTLE;
            end
            ST_SETTLE: if (zero) state <= ST_SAMPLE;
            ST_SAMPLE: begin
               if (mismatch_o) begin
                  err_cnt_o <= err_cnt_o + 1'b1;
                  if (!fail_valid_o) begin
                     fail_vec_o   <= stim_o;
                     fail_valid_o <= 1'b1;
                  end
               end
               if (last) state <= ST_DONE;
               else begin
                  stim_o <= stim_o + 1'b1;
                  state  <= ST_SETTLE;
               end
            end
         endcase
      end
   end
endmodule

// File: tb/tb_exhaustive_sweep_checker.sv
// tb_exhaustive_sweep_checker: directed checks of the sweep engine in two configurations.
module tb_exhaustive_sweep_checker;
   logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, start2 = 1'b0;
   always #5 clk = ~clk;
   int   mode = 0;
   logic x_mode = 1'b0;
   int   vectors = 0, miscompares = 0;

   logic [4:0] stim, fv;
   logic       busy, sample, mism, done, pass, fvalid, gold, dut;
   logic [5:0] err;
   assign gold = ^stim;
   assign dut  = gold ^ (mode == 2 || (mode == 1 && (stim == 5'd3 || stim == 5'd22)));

   exhaustive_sweep_checker u1 (
      .clk(clk), .rst_n(rst_n), .start_i(start), .dut_i(dut), .gold_i(gold),
      .stim_o(stim), .busy_o(busy), .sample_o(sample), .mismatch_o(mism), .done_o(done),
      .pass_o(pass), .err_cnt_o(err), .fail_vec_o(fv), .fail_valid_o(fvalid)
   );

   logic [2:0] stim2, fv2;
   logic [1:0] gold2, dut2;
   logic [3:0] err2;
   logic       busy2, sample2, mism2, done2, pass2, fvalid2;
   assign dut2  = stim2[1:0] ^ {stim2[2], stim2[2]};
   assign gold2 = (x_mode && stim2 == 3'd6) ? 2'bxx : dut2;

   exhaustive_sweep_checker #(.N_IN(3), .N_OUT(2), .SETTLE(1)) u2 (
      .clk(clk), .rst_n(rst_n), .start_i(start2), .dut_i(dut2), .gold_i(gold2),
      .stim_o(stim2), .busy_o(busy2), .sample_o(sample2), .mismatch_o(mism2), .done_o(done2),
      .pass_o(pass2), .err_cnt_o(err2), .fail_vec_o(fv2), .fail_valid_o(fvalid2)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic logic exp_m(input logic [4:0] s);
      return mode == 2 || (mode == 1 && (s == 5'd3 || s == 5'd22));
   endfunction

   task automatic run1(input int pulse_at, input int exp_err, input logic [4:0] exp_fv);
      int n = 0, pulses = 0;
      start = 1'b1;
      tick;
      start = 1'b0;
      chk("start_busy", busy, 1);
      chk("start_done", done, 0);
      chk("start_err", err, 0);
      chk("start_fvalid", fvalid, 0);
      while (!done && n < 2000) begin
         start = (n == pulse_at);
         if (sample) begin
            if (pulses == 0) chk("first_sample_lat", n, 20);
            chk("order", stim, pulses);
            chk("mism", mism, exp_m(stim));
            pulses++;
         end
         tick;
         n++;
      end
      start = 1'b0;
      chk("sweep_cycles", n, 672);
      chk("pulses", pulses, 32);
      chk("err_cnt", err, exp_err);
      chk("pass", pass, exp_err == 0);
      chk("fail_valid", fvalid, exp_err != 0);
      chk("fail_vec", fv, exp_fv);
      chk("stim_held", stim, 31);
   endtask

   task automatic run2(input int exp_err, input logic [2:0] exp_fv);
      int n = 0;
      start2 = 1'b1;
      tick;
      start2 = 1'b0;
      while (!done2 && n < 200) begin
         tick;
         n++;
      end
      chk("small_cycles", n, 16);
      chk("small_err", err2, exp_err);
      chk("small_pass", pass2, exp_err == 0);
      chk("small_fvalid", fvalid2, exp_err != 0);
      chk("small_fvec", fv2, exp_fv);
   endtask

   initial begin
      int n = 0;
      #1;
      chk("rst_stim", stim, 0);
      chk("rst_busy", busy, 0);
      chk("rst_sample", sample, 0);
      chk("rst_mism", mism, 0);
      chk("rst_done", done, 0);
      chk("rst_pass", pass, 0);
      chk("rst_err", err, 0);
      chk("rst_fvec", fv, 0);
      chk("rst_fvalid", fvalid, 0);
      repeat (2) tick;
      #2 rst_n = 1'b1;
      tick;
      mode = 0; run1(-1, 0, 5'd0);
      mode = 1; run1(-1, 2, 5'd3);
      mode = 2; run1(-1, 32, 5'd0);
      mode = 0; run1(-1, 0, 5'd0);
      start = 1'b1;
      tick;
      start = 1'b0;
      while (!(stim == 5'd13 && busy && !sample) && n < 2000) begin
         tick;
         n++;
      end
      chk("reach_13", stim, 13);
      repeat (3) tick;
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_stim", stim, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_done", done, 0);
      chk("mid_rst_err", err, 0);
      chk("mid_rst_fvalid", fvalid, 0);
      @(negedge clk) rst_n = 1'b1;
      tick;
      run1(-1, 0, 5'd0);
      run1(7, 0, 5'd0);
      run1(400, 0, 5'd0);
      x_mode = 1'b0; run2(0, 3'd0);
      x_mode = 1'b1; run2(1, 3'd6);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
